legv8_main_control: RTL

Multicycle main control unit for the LEGv8 CPU datapath. Decodes the latched instruction opcode field and sequences fetch, decode, execute, memory and write-back states. It drives the 2-bit `ALUOp` consumed by the downstream ALU control stage, plus all datapath strobes. It also stalls on memory handshakes and counts retired instructions.

---
 rtl/legv8_pkg.sv | 33 +++
 rtl/legv8_op_decode.sv | 26 ++
 rtl/legv8_main_control.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcode patterns, ALUOp/PCSel encodings,
// controller state and opcode-class enums.
package legv8_pkg;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  // Prefix-matched opcodes compare only the upper bits of inst31_21.
  localparam logic [9:0] PFX_ADDI = 10'b1001000100;
  localparam logic [7:0] PFX_CBZ  = 8'b10110100;
  localparam logic [5:0] PFX_B    = 6'b000101;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_CBZ, S_BR, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_ADDI, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_B, CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/legv8_op_decode.sv
// Combinational opcode classifier: inst31_21 -> op_class_t.
module legv8_op_decode
  import legv8_pkg::*;
(
  input  logic [10:0] inst31_21,
  output op_class_t   op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    if (inst31_21 == OP_LDUR)
      op_class = CLS_LDUR;
    else if (inst31_21 == OP_STUR)
      op_class = CLS_STUR;
    else if (inst31_21 == OP_ADD || inst31_21 == OP_SUB ||
             inst31_21 == OP_AND || inst31_21 == OP_ORR)
      op_class = CLS_R;
    else if (inst31_21[10:1] == PFX_ADDI)
      op_class = CLS_ADDI;
    else if (inst31_21[10:3] == PFX_CBZ)
      op_class = CLS_CBZ;
    else if (inst31_21[10:5] == PFX_B)
      op_class = CLS_B;
  end

endmodule

// File: rtl/legv8_main_control.sv
// Multicycle LEGv8 main control FSM with memory-handshake stalls,
// sticky illegal-opcode flag and retired-instruction counter.
module legv8_main_control
  import legv8_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      inst31_21,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       ALUOp,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSel,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state, next_state;
  op_class_t  dec_class, op_class_q;
  logic       illegal_q;
  logic       retire;

  legv8_op_decode u_op_decode (
    .inst31_21 (inst31_21),
    .op_class  (dec_class)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      op_class_q  <= CLS_ILLEGAL;
      illegal_q   <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE)
        op_class_q <= dec_class;
      if (next_state == S_HALT)
        illegal_q <= 1'b1;
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        unique case (dec_class)
          CLS_R:             next_state = S_EXEC_R;
          CLS_ADDI:          next_state = S_EXEC_I;
          CLS_LDUR, CLS_STUR: next_state = S_MEM_ADDR;
          CLS_CBZ:           next_state = S_CBZ;
          CLS_B:             next_state = S_BR;
          default:           next_state = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: next_state = S_WB_ALU;
      S_MEM_ADDR: next_state = (op_class_q == CLS_LDUR) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) next_state = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_CBZ, S_BR: next_state = S_FETCH;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_FETCH;
    endcase
  end

  assign retire = (state != S_FETCH) && (next_state == S_FETCH);

  // Reg2Loc in DECODE follows the opcode being decoded, since the class
  // register only captures it at the end of that cycle.
  always_comb begin
    ALUOp    = ALUOP_ADD;
    PCSel    = PCSEL_PC4;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:   Reg2Loc = (dec_class == CLS_STUR) || (dec_class == CLS_CBZ);
      S_EXEC_R:   ALUOp = ALUOP_FUNC;
      S_EXEC_I: begin
        ALUOp  = ALUOP_FUNC;
        ALUSrc = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrc  = 1'b1;
        Reg2Loc = (op_class_q == CLS_STUR);
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        ALUSrc  = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        ALUSrc   = 1'b1;
        Reg2Loc  = 1'b1;
      end
      S_WB_ALU:   RegWrite = 1'b1;
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_CBZ: begin
        ALUOp   = ALUOP_CBZ;
        Reg2Loc = 1'b1;
        PCSel   = PCSEL_BR;
        PCWrite = zero;
      end
      S_BR: begin
        PCSel   = PCSEL_BR;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ALUOp    = ALUOP_ADD;
      PCSel    = PCSEL_PC4;
      Reg2Loc  = 1'b0;
      ALUSrc   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
    end
  end

  assign illegal = illegal_q & ~reset;

endmodule
